uniman_ctrl_agent: RTL and testbench
====================================

# uniman_ctrl_agent

Control-plane responder for the UniMan firewall monitor. It terminates 134-bit FAST2.0 control packets arriving on the `cin` interface and decodes them into single read or write requests on the connection manager's control port. It then returns one response packet per accepted command on the `cout` interface. It sits beside `connection_manager` inside the UniMan top level and gives the UA host access to UniMan tables and registers.

## Interface
Parameters:
- LMID, 8: module ID of this block; commands carrying any other destination ID are dropped.
- w_pkt, 134: FAST2.0 beat width. Fields are `[133:132]` beat type (01 head, 11 body, 10 tail), `[131:128]` don't-care, `[127:0]` payload.
- w_addr, 32: control address width.
- w_data, 32: control data width.
- TIMEOUT, 16'd1024: maximum cycles to wait for a read response.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- cin_data_wr, in, 1: input beat valid.
- cin_data, in, w_pkt: input beat.
- cin_ready, out, 1: agent can accept a beat.
- cout_data_wr, out, 1: output beat valid, one cycle per beat.
- cout_data, out, w_pkt: output beat.
- cout_ready, in, 1: downstream can accept a beat.
- ctrl_req_valid, out, 1: one-cycle request pulse.
- ctrl_req_opt, out, 2: request type, 2'b01 read or 2'b10 write.
- ctrl_req_addr, out, w_addr: request address.
- ctrl_req_data, out, w_data: write data.
- ctrl_rsp_valid, in, 1: read data valid.
- ctrl_rsp_data, in, w_data: read data.
- drop_cnt, out, 16: count of dropped packets; saturates at 16'hFFFF.

## Operation
Command packet format. Each command packet is exactly 3 beats:
- Head beat: the 128-bit payload is FAST metadata. It is stored and echoed unchanged in the response.
- Command beat (type 11) payload:
  - `[127:120]` opcode: 8'h01 read, 8'h02 write.
  - `[119:112]` destination LMID.
  - `[111:96]` sequence number.
  - `[95:64]` address.
- Tail beat (type 10) payload: `[31:0]` write data (ignored for reads).

State machine:
- **IDLE.** Accept a head beat and go to CMD. Any non-head beat increments drop_cnt and the state stays IDLE.
- **CMD.**
  - A type-11 beat is latched and the state goes to DATA.
  - A tail beat is a short packet: increment drop_cnt and go to IDLE.
  - A head beat is a restart: increment drop_cnt and stay in CMD with the new metadata.
- **DATA.**
  - A tail beat goes to DECODE.
  - A type-11 beat goes to DISCARD.
  - A head beat is handled as in CMD.
- **DISCARD.** Beats are consumed until a tail beat. On the tail, increment drop_cnt once and go to IDLE.
- **DECODE** (1 cycle):
  - LMID mismatch: increment drop_cnt, go to IDLE, send no response.
  - Read: assert ctrl_req_valid with opt 01, go to WAIT_RSP.
  - Write: assert ctrl_req_valid with opt 10, status 8'h00, go to SEND_HEAD.
  - Other opcode: no request, status 8'h02, go to SEND_HEAD.
- **WAIT_RSP.** A 16-bit counter starts at 0.
  - ctrl_rsp_valid: latch the data, status 8'h00.
  - Counter reaches TIMEOUT-1 without a response: data 0, status 8'h01.
  - Either way go to SEND_HEAD.
  - ctrl_rsp_valid arriving in any other state is ignored.
- **SEND_HEAD / SEND_CMD / SEND_TAIL.** One response beat is emitted per state. After SEND_TAIL the state returns to IDLE.

Response beat contents:
- Head: type 01, payload is the stored metadata.
- Command beat: type 11, payload is:
  - `[127:120]` opcode OR'ed with 8'h80.
  - `[119:112]` LMID.
  - `[111:96]` sequence number.
  - `[95:64]` address.
  - `[63:56]` status.
  - remaining bits 0.
- Tail: type 10, payload `[31:0]` is the read data (0 for writes, errors and timeouts), remaining bits 0.
- Bits `[131:128]` of every response beat are 4'h0.

## Timing
- Reset values: cin_ready=0, cout_data_wr=0, cout_data=0, ctrl_req_valid=0, ctrl_req_opt/addr/data=0, drop_cnt=0, state IDLE.
- cin_ready is registered:
  - It is 1 in IDLE, CMD, DATA and DISCARD.
  - It goes to 0 from the edge that accepts a good tail (entry to DECODE).
  - It returns to 1 on the edge that leaves SEND_TAIL or DECODE→IDLE.
- A beat on cin is accepted only when cin_data_wr=1 and cin_ready=1. Beats presented while cin_ready=0 are ignored and not counted.
- ctrl_req_valid is high exactly in the DECODE cycle, which is the cycle after tail acceptance. ctrl_req_opt, ctrl_req_addr and ctrl_req_data hold their values until the next request.
- Send states:
  - A beat is emitted only if cout_ready=1 in that cycle. In that case cout_data_wr=1 and cout_data are registered at the next edge, and the state advances.
  - If cout_ready=0 the state holds and cout_data_wr=0. cout_data_wr is never high for two beats without cout_ready=1 in the preceding cycle.
- Write latency: tail accepted at edge T → request pulse in cycle T..T+1 → head out at T+2 → command beat at T+3 → tail at T+4, with cout_ready held at 1.
- Reset asserted mid-operation:
  - All state is abandoned immediately.
  - No partial response is completed after release.
  - drop_cnt is cleared.

## Test plan
- Write, cout_ready=1: head(meta=128'hA5..), cmd(op 02, LMID 8, seq 16'h0007, addr 32'h10), tail(data 32'hDEADBEEF) → one ctrl_req_valid pulse with opt 10, addr 32'h10, data DEADBEEF. The response echoes meta, has op 8'h82, seq 7, status 0, tail data 0, and cout_data_wr is high for exactly 3 cycles.
- Read with response: read addr 32'h20, ctrl_rsp_data=32'h12345678 returned 5 cycles after the request → response status 0, tail `[31:0]`=32'h12345678.
- Read timeout: no ctrl_rsp_valid → response emitted TIMEOUT cycles after the request with status 8'h01 and data 0. A ctrl_rsp_valid arriving afterwards is ignored.
- Drops: LMID 8'h09 command; a 2-beat packet; a 5-beat packet; an orphan tail in IDLE → no ctrl_req_valid, no cout traffic, drop_cnt=4, cin_ready stays 1 except for the DECODE cycle of the LMID case.
- Backpressure: read response with cout_ready toggling 1,0,0,1,0,1 → beats appear only after cycles with cout_ready=1, in order head/cmd/tail, and cin_ready stays 0 until the tail is sent.
- Reset mid-response: reset asserted while in SEND_CMD → all outputs 0 immediately. After release, cin_ready=1 one cycle later and no residual beats appear.

Source files
------------

// File: rtl/uniman_ctrl_agent.sv
// Control-plane responder: turns 3-beat FAST2.0 command packets into single
// read/write requests on the connection manager control port and answers each one.
module uniman_ctrl_agent #(
  parameter logic [7:0]  LMID    = 8'd8,
  parameter int          w_pkt   = 134,
  parameter int          w_addr  = 32,
  parameter int          w_data  = 32,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cin_data_wr,
  input  logic [w_pkt-1:0]  cin_data,
  output logic              cin_ready,
  output logic              cout_data_wr,
  output logic [w_pkt-1:0]  cout_data,
  input  logic              cout_ready,
  output logic              ctrl_req_valid,
  output logic [1:0]        ctrl_req_opt,
  output logic [w_addr-1:0] ctrl_req_addr,
  output logic [w_data-1:0] ctrl_req_data,
  input  logic              ctrl_rsp_valid,
  input  logic [w_data-1:0] ctrl_rsp_data,
  output logic [15:0]       drop_cnt
);

  localparam logic [1:0] BT_HEAD = 2'b01;
  localparam logic [1:0] BT_BODY = 2'b11;
  localparam logic [1:0] BT_TAIL = 2'b10;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CMD       = 4'd1;
  localparam logic [3:0] DATA      = 4'd2;
  localparam logic [3:0] DISCARD   = 4'd3;
  localparam logic [3:0] DECODE    = 4'd4;
  localparam logic [3:0] WAIT_RSP  = 4'd5;
  localparam logic [3:0] SEND_HEAD = 4'd6;
  localparam logic [3:0] SEND_CMD  = 4'd7;
  localparam logic [3:0] SEND_TAIL = 4'd8;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  logic [3:0]        state;
  logic [3:0]        nextState;
  logic              dropInc;
  logic              accept;
  logic [1:0]        beatType;
  logic [127:0]      payload;
  logic [127:0]      metaReg;
  logic [7:0]        opReg;
  logic [7:0]        lmidReg;
  logic [15:0]       seqReg;
  logic [w_addr-1:0] addrReg;
  logic [7:0]        statusReg;
  logic [w_data-1:0] rdData;
  logic [15:0]       waitCnt;
  logic [w_pkt-1:0]  sendBeat;
  logic              unusedBits;

  assign accept     = cin_data_wr && cin_ready;
  assign beatType   = cin_data[w_pkt-1 -: 2];
  assign payload    = cin_data[127:0];
  assign unusedBits = ^cin_data[131:128];

  always_comb begin
    nextState = state;
    dropInc   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (beatType == BT_HEAD) nextState = CMD;
          else                     dropInc   = 1'b1;
        end
      end
      CMD: begin
        if (accept) begin
          case (beatType)
            BT_HEAD: dropInc = 1'b1;
            BT_BODY: nextState = DATA;
            BT_TAIL: begin
              dropInc   = 1'b1;
              nextState = IDLE;
            end
            default: ;
          endcase
        end
      end
      DATA: begin
        if (accept) begin
          case (beatType)
            BT_HEAD: begin
              dropInc   = 1'b1;
              nextState = CMD;
            end
            BT_BODY: nextState = DISCARD;
            BT_TAIL: nextState = DECODE;
            default: ;
          endcase
        end
      end
      DISCARD: begin
        if (accept && beatType == BT_TAIL) begin
          dropInc   = 1'b1;
          nextState = IDLE;
        end
      end
      DECODE: begin
        if (lmidReg != LMID) begin
          dropInc   = 1'b1;
          nextState = IDLE;
        end else if (opReg == OP_READ) begin
          nextState = WAIT_RSP;
        end else begin
          nextState = SEND_HEAD;
        end
      end
      WAIT_RSP: begin
        if (ctrl_rsp_valid || waitCnt == TIMEOUT - 16'd1) nextState = SEND_HEAD;
      end
      SEND_HEAD: if (cout_ready) nextState = SEND_CMD;
      SEND_CMD:  if (cout_ready) nextState = SEND_TAIL;
      SEND_TAIL: if (cout_ready) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    sendBeat = '0;
    case (state)
      SEND_HEAD: sendBeat = {BT_HEAD, 4'h0, metaReg};
      SEND_CMD:  sendBeat = {BT_BODY, 4'h0, opReg | 8'h80, LMID, seqReg, addrReg, statusReg, 56'h0};
      SEND_TAIL: sendBeat = {BT_TAIL, 4'h0, {(128 - w_data){1'b0}}, rdData};
      default:   sendBeat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cin_ready      <= 1'b0;
      cout_data_wr   <= 1'b0;
      cout_data      <= '0;
      ctrl_req_valid <= 1'b0;
      ctrl_req_opt   <= 2'b00;
      ctrl_req_addr  <= '0;
      ctrl_req_data  <= '0;
      drop_cnt       <= 16'd0;
      metaReg        <= '0;
      opReg          <= 8'd0;
      lmidReg        <= 8'd0;
      seqReg         <= 16'd0;
      addrReg        <= '0;
      statusReg      <= 8'd0;
      rdData         <= '0;
      waitCnt        <= 16'd0;
    end else begin
      state          <= nextState;
      cin_ready      <= (nextState == IDLE) || (nextState == CMD) ||
                        (nextState == DATA) || (nextState == DISCARD);
      ctrl_req_valid <= 1'b0;
      cout_data_wr   <= 1'b0;

      if (dropInc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      // Any head seen while assembling a packet restarts it with new metadata.
      if (accept && beatType == BT_HEAD &&
          (state == IDLE || state == CMD || state == DATA))
        metaReg <= payload;

      if (state == CMD && accept && beatType == BT_BODY) begin
        opReg   <= payload[127:120];
        lmidReg <= payload[119:112];
        seqReg  <= payload[111:96];
        addrReg <= payload[64 +: w_addr];
      end

      // Request is registered on the tail edge so the pulse lands in DECODE.
      if (state == DATA && accept && beatType == BT_TAIL && lmidReg == LMID &&
          (opReg == OP_READ || opReg == OP_WRITE)) begin
        ctrl_req_valid <= 1'b1;
        ctrl_req_opt   <= (opReg == OP_READ) ? 2'b01 : 2'b10;
        ctrl_req_addr  <= addrReg;
        ctrl_req_data  <= payload[w_data-1:0];
      end

      if (state == DECODE) begin
        rdData    <= '0;
        waitCnt   <= 16'd0;
        statusReg <= (opReg == OP_READ || opReg == OP_WRITE) ? 8'h00 : 8'h02;
      end

      if (state == WAIT_RSP) begin
        if (ctrl_rsp_valid) begin
          rdData    <= ctrl_rsp_data;
          statusReg <= 8'h00;
        end else if (waitCnt == TIMEOUT - 16'd1) begin
          rdData    <= '0;
          statusReg <= 8'h01;
        end else begin
          waitCnt <= waitCnt + 16'd1;
        end
      end

      if ((state == SEND_HEAD || state == SEND_CMD || state == SEND_TAIL) && cout_ready) begin
        cout_data_wr <= 1'b1;
        cout_data    <= sendBeat;
      end
    end
  end

endmodule

// File: tb/tb_uniman_ctrl_agent.sv
// Scoreboard bench for uniman_ctrl_agent: expected requests and response beats
// are queued when commands are driven and compared as the agent produces them.
module tb_uniman_ctrl_agent;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cin_data_wr = 1'b0;
  logic [133:0] cin_data = '0;
  logic         cin_ready;
  logic         cout_data_wr;
  logic [133:0] cout_data;
  logic         cout_ready = 1'b1;
  logic         ctrl_req_valid;
  logic [1:0]   ctrl_req_opt;
  logic [31:0]  ctrl_req_addr;
  logic [31:0]  ctrl_req_data;
  logic         ctrl_rsp_valid = 1'b0;
  logic [31:0]  ctrl_rsp_data = '0;
  logic [15:0]  drop_cnt;

  int errCnt = 0;
  int chkCnt = 0;
  int cycleCnt = 0;
  int tailCycle = 0;
  int lowCnt = 0;
  int beatsSeen = 0;
  logic readyPrev = 1'b1;
  logic bpMode = 1'b0;

  logic [133:0] expBeats[$];
  logic [65:0]  expReqs[$];

  uniman_ctrl_agent dut (
    .clk(clk), .reset(reset),
    .cin_data_wr(cin_data_wr), .cin_data(cin_data), .cin_ready(cin_ready),
    .cout_data_wr(cout_data_wr), .cout_data(cout_data), .cout_ready(cout_ready),
    .ctrl_req_valid(ctrl_req_valid), .ctrl_req_opt(ctrl_req_opt),
    .ctrl_req_addr(ctrl_req_addr), .ctrl_req_data(ctrl_req_data),
    .ctrl_rsp_valid(ctrl_rsp_valid), .ctrl_rsp_data(ctrl_rsp_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkVal(input string tag, input logic [133:0] got, input logic [133:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    logic [133:0] e;
    logic [65:0]  r;
    if (reset) begin
      if (!cin_ready) lowCnt++;
      if (cout_data_wr) begin
        beatsSeen++;
        checkVal("bp_rule", 134'(readyPrev), 134'(1));
        if (expBeats.size() == 0) checkVal("unexp_beat", 134'(cout_data_wr), 134'(0));
        else begin
          e = expBeats.pop_front();
          checkVal("rsp_beat", cout_data, e);
          $display("rsp beat type=%b payload=%h", cout_data[133:132], cout_data[127:0]);
        end
      end
      if (ctrl_req_valid) begin
        if (expReqs.size() == 0) checkVal("unexp_req", 134'(ctrl_req_valid), 134'(0));
        else begin
          r = expReqs.pop_front();
          checkVal("ctrl_req", 134'({ctrl_req_opt, ctrl_req_addr,
                   (ctrl_req_opt == 2'b01) ? 32'h0 : ctrl_req_data}), 134'(r));
          $display("ctrl req opt=%b addr=%h data=%h", ctrl_req_opt, ctrl_req_addr, ctrl_req_data);
        end
      end
      if (bpMode && expBeats.size() > 0) checkVal("cin_ready_bp", 134'(cin_ready), 134'(0));
    end
    readyPrev = cout_ready;
  end

  task automatic sendBeat(input logic [1:0] bt, input logic [127:0] pl);
    int n = 0;
    cin_data    = {bt, 4'h0, pl};
    cin_data_wr = 1'b1;
    @(negedge clk);
    while (!cin_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cin_ready) checkVal("cin_wait", 134'(cin_ready), 134'(1));
    @(posedge clk);
    #1;
    cin_data_wr = 1'b0;
  endtask

  task automatic sendPkt(input logic [127:0] meta, input logic [7:0] op, input logic [7:0] lmid,
                         input logic [15:0] seq, input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] rdStat, input logic [31:0] rdVal);
    logic [7:0]  st;
    logic [31:0] td;
    sendBeat(2'b01, meta);
    sendBeat(2'b11, {op, lmid, seq, addr, 64'h0});
    sendBeat(2'b10, {96'h0, data});
    tailCycle = cycleCnt;
    if (lmid == 8'h08) begin
      if (op == 8'h01 || op == 8'h02)
        expReqs.push_back({(op == 8'h01) ? 2'b01 : 2'b10, addr, (op == 8'h01) ? 32'h0 : data});
      st = (op == 8'h01) ? rdStat : (op == 8'h02) ? 8'h00 : 8'h02;
      td = (op == 8'h01) ? rdVal : 32'h0;
      expBeats.push_back({2'b01, 4'h0, meta});
      expBeats.push_back({2'b11, 4'h0, op | 8'h80, 8'h08, seq, addr, st, 56'h0});
      expBeats.push_back({2'b10, 4'h0, 96'h0, td});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, lat, found, lowBase, seenBase;
    logic [5:0] pat;

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_cin_ready", 134'(cin_ready), 134'(0));
    checkVal("rst_cout", {cout_data_wr, cout_data[132:0]}, 134'(0));
    checkVal("rst_req", 134'({ctrl_req_valid, ctrl_req_opt, ctrl_req_addr, ctrl_req_data}), 134'(0));
    checkVal("rst_drop", 134'(drop_cnt), 134'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checkVal("rel_cin_ready", 134'(cin_ready), 134'(1));
    @(posedge clk); #1;

    // Write with latency window
    sendPkt({16{8'hA5}}, 8'h02, 8'h08, 16'h0007, 32'h10, 32'hDEADBEEF, 8'h00, 32'h0);
    first = -1; cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cout_data_wr) begin
        cnt++;
        if (first < 0) first = cycleCnt - tailCycle;
      end
    end
    checkVal("wr_first_beat", 134'(first), 134'(2));
    checkVal("wr_beat_count", 134'(cnt), 134'(3));
    @(posedge clk); #1;

    // Read with response 5 cycles after request
    sendPkt(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 8'h01, 8'h08, 16'h0011,
            32'h20, 32'h0, 8'h00, 32'h12345678);
    repeat (5) @(posedge clk);
    #1 ctrl_rsp_valid = 1'b1; ctrl_rsp_data = 32'h12345678;
    @(posedge clk); #1 ctrl_rsp_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Unknown opcode: error status, no request
    sendPkt(128'h5A, 8'h33, 8'h08, 16'h0100, 32'h44, 32'h55, 8'h00, 32'h0);
    repeat (8) @(posedge clk); #1;

    // Read timeout, then a late response that must be ignored
    ctrl_rsp_data = 32'hFFFF0000;
    sendPkt(128'h77, 8'h01, 8'h08, 16'h0200, 32'h30, 32'h0, 8'h01, 32'h0);
    found = 0; lat = 0;
    for (int k = 0; k < 1200 && found == 0; k++) begin
      @(negedge clk);
      if (cout_data_wr) begin
        found = 1;
        lat = cycleCnt - tailCycle;
      end
    end
    checkVal("tmo_seen", 134'(found), 134'(1));
    checkVal("tmo_lat_ok", 134'(lat >= 1024 && lat <= 1026), 134'(1));
    repeat (4) @(posedge clk);
    #1 ctrl_rsp_valid = 1'b1;
    @(posedge clk); #1 ctrl_rsp_valid = 1'b0;
    repeat (10) @(posedge clk); #1;

    // Backpressure on a read response
    seenBase = beatsSeen;
    pat = 6'b101001;
    sendPkt(128'hBB, 8'h01, 8'h08, 16'h0300, 32'h40, 32'h0, 8'h00, 32'hCAFEF00D);
    bpMode = 1'b1;
    repeat (3) @(posedge clk);
    #1 ctrl_rsp_valid = 1'b1; ctrl_rsp_data = 32'hCAFEF00D;
    @(posedge clk); #1 ctrl_rsp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cout_ready = pat[i];
      @(posedge clk); #1;
    end
    cout_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    bpMode = 1'b0;
    checkVal("bp_beats", 134'(beatsSeen - seenBase), 134'(3));

    // Drops: wrong LMID, short packet, long packet, orphan tail
    lowBase = lowCnt;
    seenBase = beatsSeen;
    sendPkt(128'h1, 8'h02, 8'h09, 16'h0400, 32'h50, 32'h1, 8'h00, 32'h0);
    sendBeat(2'b01, 128'h2);
    sendBeat(2'b10, 128'h3);
    sendBeat(2'b01, 128'h4);
    sendBeat(2'b11, {8'h02, 8'h08, 16'h0500, 32'h60, 64'h0});
    sendBeat(2'b11, 128'h5);
    sendBeat(2'b11, 128'h6);
    sendBeat(2'b10, 128'h7);
    sendBeat(2'b10, 128'h8);
    repeat (5) @(posedge clk); #1;
    checkVal("drop_cnt", 134'(drop_cnt), 134'(4));
    checkVal("drop_low_cycles", 134'(lowCnt - lowBase), 134'(1));
    checkVal("drop_no_beats", 134'(beatsSeen - seenBase), 134'(0));

    // Reset while in SEND_CMD
    cout_ready = 1'b0;
    sendPkt(128'hCC, 8'h02, 8'h08, 16'h0600, 32'h70, 32'h99, 8'h00, 32'h0);
    @(posedge clk); #1 cout_ready = 1'b1;
    @(posedge clk); #1 cout_ready = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkVal("mid_rst_cout", {cout_data_wr, cout_data[132:0]}, 134'(0));
    checkVal("mid_rst_misc", 134'({cin_ready, ctrl_req_valid, ctrl_req_opt, ctrl_req_addr,
                                   ctrl_req_data, drop_cnt}), 134'(0));
    expBeats.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checkVal("post_rst_cin_ready", 134'(cin_ready), 134'(1));
    seenBase = beatsSeen;
    cout_ready = 1'b1;
    repeat (20) @(negedge clk);
    checkVal("post_rst_no_beats", 134'(beatsSeen - seenBase), 134'(0));

    checkVal("sb_beats_empty", 134'(expBeats.size()), 134'(0));
    checkVal("sb_reqs_empty", 134'(expReqs.size()), 134'(0));
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
